// File: rtl/key_expand.sv
// AES-128 key schedule: one round key every five cycles using an external combinational sbox.
// Optional KEY_EXPAND_STALL_EN adds an rk_ready back-pressure input.
module key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
`ifdef KEY_EXPAND_STALL_EN
    input  logic         rk_ready,
`endif
    input  logic [7:0]   sb_in,
    output logic [7:0]   sb_a,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, LOAD, SUB, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [31:0]      w0, w1, w2, w3;
    logic [3:0][7:0]  temp;
    logic [3:0][7:0]  rot_b;
    logic [31:0]      t, w0_nx, w1_nx, w2_nx, w3_nx;
    logic [7:0]       rcon;
    logic [3:0]       round;
    logic [1:0]       bc;
    logic             hs;
    logic             last;

`ifdef KEY_EXPAND_STALL_EN
    assign hs = rk_ready;
`else
    assign hs = 1'b1;
`endif

    assign last  = (round == 4'd10);
    assign rot_b = {w3[23:0], w3[31:24]};
    assign t     = temp ^ {rcon, 24'h0};
    assign w0_nx = w0 ^ t;
    assign w1_nx = w1 ^ w0_nx;
    assign w2_nx = w2 ^ w1_nx;
    assign w3_nx = w3 ^ w2_nx;

    assign rk       = {w0, w1, w2, w3};
    assign rk_round = round;
    assign rk_valid = (state == LOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: if (hs) state_nx = last ? DONE : SUB;
            SUB:  if (bc == 2'd3) state_nx = CALC;
            CALC: state_nx = LOAD;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Byte 0 is fetched during the presentation cycle, so a round costs
    // present+3 SUB+CALC = 5 cycles.
    always_comb begin
        sb_a = 8'h00;
        if ((state == LOAD && !last) || state == SUB)
            sb_a = rot_b[2'd3 - bc];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            w0    <= '0;
            w1    <= '0;
            w2    <= '0;
            w3    <= '0;
            temp  <= '0;
            rcon  <= 8'h01;
            round <= '0;
            bc    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    {w0, w1, w2, w3} <= key_in;
                    rcon  <= 8'h01;
                    round <= '0;
                    bc    <= '0;
                end
                LOAD: if (hs && !last) begin
                    temp[2'd3 - bc] <= sb_in;
                    bc <= bc + 2'd1;
                end
                SUB: begin
                    temp[2'd3 - bc] <= sb_in;
                    bc <= bc + 2'd1;
                end
                CALC: begin
                    w0    <= w0_nx;
                    w1    <= w1_nx;
                    w2    <= w2_nx;
                    w3    <= w3_nx;
                    rcon  <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    round <= round + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_key_expand.sv
// Bench for key_expand: GF(2^8)-derived sbox, word-level AES key schedule model, FIPS vectors.
module tb_key_expand;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [7:0]   sb_a, sb_in;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_valid, busy, done;
`ifdef KEY_EXPAND_STALL_EN
    logic         rk_ready = 1'b1;
`endif

    int total = 0;
    int bad = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk [11];
    logic [127:0] dut_rk [11];

    always #5 clk = ~clk;
    assign sb_in = sbox_tab[sb_a];

    key_expand dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
`ifdef KEY_EXPAND_STALL_EN
        .rk_ready(rk_ready),
`endif
        .sb_in(sb_in), .sb_a(sb_a), .rk(rk), .rk_round(rk_round),
        .rk_valid(rk_valid), .busy(busy), .done(done)
    );

    typedef struct { logic [127:0] key, r1, r10; } vec_t;
    vec_t vt [3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tw;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sbox_tab[tw[31:24]], sbox_tab[tw[23:16]], sbox_tab[tw[15:8]], sbox_tab[tw[7:0]]};
                tw ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One expansion; cycle 1 is the cycle after the accepting edge.
    task automatic run(input logic [127:0] key, input int poke_c, input int rst_c,
                       input int st_round, input int st_len);
        int  nxt, t, hold, done_c;
        bit  ev;
        model(key);
        for (int r = 0; r < 11; r++) dut_rk[r] = '0;
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        nxt = 0; t = 1; done_c = -1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (rst_c > 0 && c == rst_c + 1) begin
                chk("rst_rk", rk, 0);
                chk("rst_round", rk_round, 0);
                chk("rst_valid", rk_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_sb_a", sb_a, 0);
                rst_n = 1'b1;
                break;
            end
            hold = (nxt == st_round) ? st_len : 0;
            ev = (nxt <= 10) && c >= t && c <= t + hold;
`ifdef KEY_EXPAND_STALL_EN
            rk_ready = !(nxt == st_round && c >= t && c < t + st_len);
`endif
            chk("rk_valid", rk_valid, ev);
            if (ev) begin
                chk("rk", rk, exp_rk[nxt]);
                chk("rk_round", rk_round, nxt[3:0]);
                dut_rk[nxt] = rk;
                if (c == t + hold) begin
                    nxt++;
                    t = c + 5;
                    if (nxt == 11) done_c = c + 1;
                end
            end
            chk("done", done, (c == done_c));
            if (done_c < 0 || c < done_c) chk("busy", busy, 1);
            if (done_c > 0 && c > done_c) begin
                chk("idle_busy", busy, 0);
                chk("idle_sb_a", sb_a, 0);
            end
            if (c == done_c) begin
                start  = 1'b1;
                key_in = '1;
            end
            if (c == poke_c) begin
                start  = 1'b1;
                key_in = '0;
            end
            if (c == rst_c) rst_n = 1'b0;
            if (done_c > 0 && c == done_c + 3) break;
        end
        start = 1'b0;
`ifdef KEY_EXPAND_STALL_EN
        rk_ready = 1'b1;
`endif
        if (rst_c < 0) chk("rounds_seen", 128'(nxt), 11);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        build_sbox();
        vt[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  r1:  128'ha0fafe1788542cb123a339392a6c7605,
                  r10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vt[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                  r1:  128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                  r10: 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vt[2] = '{key: 128'h0,
                  r1:  128'h62636363626363636263636362636363,
                  r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rk", rk, 0);
        chk("reset_valid", rk_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sb_a", sb_a, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run(vt[i].key, -1, -1, -1, 0);
            chk("vec_r0", dut_rk[0], vt[i].key);
            chk("vec_r1", dut_rk[1], vt[i].r1);
            chk("vec_r10", dut_rk[10], vt[i].r10);
        end

        // start during expansion must be ignored
        run(vt[0].key, 20, -1, -1, 0);
        chk("poke_r10", dut_rk[10], vt[0].r10);

        // reset mid-expansion, then no stray output, then fresh start
        run(vt[0].key, -1, 23, -1, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_rst_valid", rk_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        run(vt[1].key, -1, -1, -1, 0);
        chk("after_rst_r10", dut_rk[10], vt[1].r10);

        for (int i = 0; i < 4; i++)
            run({$urandom, $urandom, $urandom, $urandom}, -1, -1, -1, 0);

`ifdef KEY_EXPAND_STALL_EN
        run(vt[0].key, -1, -1, 4, 3);
        chk("stall_r10", dut_rk[10], vt[0].r10);
        run({$urandom, $urandom, $urandom, $urandom}, -1, -1, 10, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
